// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: one-entry hold register, busy scoreboard for hazards, and a registered valid/ready output to execute.
// Define RV32_WB_BYPASS_EN to forward same-cycle writeback data to source operands and release their hazards immediately.
module rv32_decode_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rd_o,
  output logic [6:0]  ex_opcode_o,
  output logic [2:0]  ex_funct3_o,
  output logic        ex_funct7b5_o,
  output logic        ex_illegal_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        d_v;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        use_rs1, use_rs2, use_rd, illegal;
  logic [31:0] imm;
  logic [4:0]  rd_wr;
  logic        rs1_byp, rs2_byp;
  logic [31:0] rs1_val, rs2_val;
  logic        hz, adv, accept;

  assign opcode     = d_instr[6:0];
  assign rd         = d_instr[11:7];
  assign rs1        = d_instr[19:15];
  assign rs2        = d_instr[24:20];
  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    if (d_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LUI, OP_AUIPC: begin
          use_rd = 1'b1;
          imm    = {d_instr[31:12], 12'b0};
        end
        OP_JAL: begin
          use_rd = 1'b1;
          imm    = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0};
        end
        OP_JALR, OP_LOAD, OP_IMM: begin
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          imm     = {{20{d_instr[31]}}, d_instr[31:20]};
        end
        OP_BRANCH: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm     = {{19{d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
        end
        OP_STORE: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm     = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
        end
        OP_OP: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          use_rd  = 1'b1;
        end
        OP_MISC, OP_SYSTEM: begin
          imm = {{20{d_instr[31]}}, d_instr[31:20]};
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign rd_wr = use_rd ? rd : 5'd0;

`ifdef RV32_WB_BYPASS_EN
  assign rs1_byp = wb_valid_i && (wb_rd_i == rs1);
  assign rs2_byp = wb_valid_i && (wb_rd_i == rs2);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (rs1_byp ? wb_data_i : rs1_data_i);
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (rs2_byp ? wb_data_i : rs2_data_i);

  // A bypassed source is free this cycle; a pending write to rd is never bypassed (WAW).
  assign hz = (use_rs1 && rs1 != 5'd0 && busy_q[rs1] && !rs1_byp)
           || (use_rs2 && rs2 != 5'd0 && busy_q[rs2] && !rs2_byp)
           || (rd_wr != 5'd0 && busy_q[rd_wr]);

  assign adv        = d_v && !hz && (!ex_valid_o || ex_ready_i) && !flush_i;
  assign if_ready_o = !d_v || adv;
  assign accept     = if_valid_i && if_ready_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_v     <= 1'b0;
      d_instr <= '0;
      d_pc    <= '0;
    end else if (flush_i) begin
      d_v <= 1'b0;
    end else if (accept) begin
      d_v     <= 1'b1;
      d_instr <= if_instr_i;
      d_pc    <= if_pc_i;
    end else if (adv) begin
      d_v <= 1'b0;
    end
  end

  // Clears apply first so a set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i)
      busy_d[wb_rd_i] = 1'b0;
    if (flush_i && ex_valid_o && ex_rd_o != 5'd0)
      busy_d[ex_rd_o] = 1'b0;
    if (adv && rd_wr != 5'd0)
      busy_d[rd_wr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is reset, since a stale busy bit would stall the pipe forever.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rd_o       <= '0;
      ex_opcode_o   <= '0;
      ex_funct3_o   <= '0;
      ex_funct7b5_o <= 1'b0;
      ex_illegal_o  <= 1'b0;
    end else if (adv) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= d_pc;
      ex_rs1_data_o <= rs1_val;
      ex_rs2_data_o <= rs2_val;
      ex_imm_o      <= imm;
      ex_rd_o       <= rd_wr;
      ex_opcode_o   <= opcode;
      ex_funct3_o   <= d_instr[14:12];
      ex_funct7b5_o <= d_instr[30];
      ex_illegal_o  <= illegal;
    end else if (flush_i || ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage; expectations follow the bypass build when RV32_WB_BYPASS_EN is defined.
module tb_rv32_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_instr_i, if_pc_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o, ex_illegal_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Register file stand-in: each register returns a recognisable pattern.
  assign rs1_data_i = 32'hA000_0000 | {27'd0, rs1_addr_o};
  assign rs2_data_i = 32'hB000_0000 | {27'd0, rs2_addr_o};

  rv32_decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_opcode_o(ex_opcode_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o), .ex_illegal_o(ex_illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    if_instr_i = instr;
    if_pc_i    = pc;
    if_valid_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
    wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
    tick(); tick();
    check("rst_if_ready", 32'(if_ready_o), 32'd1);
    check("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    check("rst_rs1_addr", 32'(rs1_addr_o), 32'd0);
    check("rst_ex_imm", ex_imm_o, 32'd0);
    check("rst_busy", dut.busy_q, 32'd0);
    rst_i = 1'b0;

    // addi x1,x0,5
    fetch(32'h0050_0093, 32'h100);
    tick();
    if_valid_i = 1'b0;
    check("addi_rs2_addr", 32'(rs2_addr_o), 32'd5);
    check("addi_not_yet", 32'(ex_valid_o), 32'd0);
    tick();
    check("addi_ex_valid", 32'(ex_valid_o), 32'd1);
    check("addi_rd", 32'(ex_rd_o), 32'd1);
    check("addi_imm", ex_imm_o, 32'd5);
    check("addi_rs1_x0", ex_rs1_data_o, 32'd0);
    check("addi_pc", ex_pc_o, 32'h100);
    check("addi_busy1", 32'(dut.busy_q[1]), 32'd1);

    // add x3,x1,x2 stalls on busy x1
    fetch(32'h0020_81B3, 32'h104);
    tick();
    if_valid_i = 1'b0;
    #1;
    check("add_stall_ready", 32'(if_ready_o), 32'd0);
    check("add_ex_drained", 32'(ex_valid_o), 32'd0);
    tick();
    check("add_still_stall", 32'(if_ready_o), 32'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd7;
    #1;
`ifdef RV32_WB_BYPASS_EN
    check("add_byp_ready", 32'(if_ready_o), 32'd1);
    tick();
    wb_valid_i = 1'b0;
    check("add_byp_valid", 32'(ex_valid_o), 32'd1);
    check("add_byp_rs1", ex_rs1_data_o, 32'd7);
`else
    check("add_wb_ready", 32'(if_ready_o), 32'd0);
    tick();
    wb_valid_i = 1'b0;
    #1;
    check("add_release_ready", 32'(if_ready_o), 32'd1);
    check("add_release_noex", 32'(ex_valid_o), 32'd0);
    tick();
    check("add_valid", 32'(ex_valid_o), 32'd1);
    check("add_rs1", ex_rs1_data_o, 32'hA000_0001);
`endif
    check("add_rs2", ex_rs2_data_o, 32'hB000_0002);
    check("add_rd", 32'(ex_rd_o), 32'd3);
    check("add_opcode", 32'(ex_opcode_o), 32'h33);
    check("add_busy", dut.busy_q, 32'h0000_0008);

    // lui x5,0x12345 held by execute back-pressure; lui x8,0x1 waits in D
    fetch(32'h1234_52B7, 32'h108);
    tick();
    ex_ready_i = 1'b0;
    fetch(32'h0000_1437, 32'h10C);
    tick();
    if_valid_i = 1'b0;
    check("lui_rd", 32'(ex_rd_o), 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("lui_hold_valid", 32'(ex_valid_o), 32'd1);
      check("lui_hold_imm", ex_imm_o, 32'h1234_5000);
      check("lui_fetch_stall", 32'(if_ready_o), 32'd0);
      tick();
    end
    ex_ready_i = 1'b1;
    #1;
    check("lui_release_ready", 32'(if_ready_o), 32'd1);
    tick();
    check("lui8_imm", ex_imm_o, 32'h0000_1000);
    check("lui8_rd", 32'(ex_rd_o), 32'd8);

    // flush with addi x4 in execute and addi x9 in D
    fetch(32'h0010_0213, 32'h110);
    tick();
    fetch(32'h0020_0493, 32'h114);
    tick();
    if_valid_i = 1'b0; ex_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    check("flush_pre_rd", 32'(ex_rd_o), 32'd4);
    check("flush_pre_ready", 32'(if_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_ex_valid", 32'(ex_valid_o), 32'd0);
    check("flush_if_ready", 32'(if_ready_o), 32'd1);
    check("flush_busy", dut.busy_q, 32'h0000_0128);

    // all-ones is illegal
    ex_ready_i = 1'b1;
    fetch(32'hFFFF_FFFF, 32'h118);
    tick();
    if_valid_i = 1'b0;
    tick();
    check("ill_valid", 32'(ex_valid_o), 32'd1);
    check("ill_flag", 32'(ex_illegal_o), 32'd1);
    check("ill_rd", 32'(ex_rd_o), 32'd0);
    check("ill_imm", ex_imm_o, 32'd0);
    check("ill_busy", dut.busy_q, 32'h0000_0128);

    // addi x6,x0,3 advancing while x6 writes back: set wins
    fetch(32'h0030_0313, 32'h11C);
    tick();
    if_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd6;
    tick();
    wb_valid_i = 1'b0;
    check("setwin_busy6", 32'(dut.busy_q[6]), 32'd1);
    check("setwin_rd", 32'(ex_rd_o), 32'd6);
    check("setwin_imm", ex_imm_o, 32'd3);
    check("setwin_illegal", 32'(ex_illegal_o), 32'd0);

    // sw x0,-4(x0): S immediate, no destination
    fetch(32'hFE00_2E23, 32'h120);
    tick();
    if_valid_i = 1'b0;
    tick();
    check("sw_imm", ex_imm_o, 32'hFFFF_FFFC);
    check("sw_rd", 32'(ex_rd_o), 32'd0);
    check("sw_funct3", 32'(ex_funct3_o), 32'd2);
    check("sw_busy", dut.busy_q, 32'h0000_0168);

    // addi x5,x0,1 blocked by pending write to x5 (WAW)
    fetch(32'h0010_0293, 32'h124);
    tick();
    if_valid_i = 1'b0;
    #1;
    check("waw_stall", 32'(if_ready_o), 32'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    tick();
    wb_valid_i = 1'b0;
    #1;
    check("waw_release", 32'(if_ready_o), 32'd1);

    // asynchronous reset mid-operation
    rst_i = 1'b1;
    #1;
    check("midrst_ex_valid", 32'(ex_valid_o), 32'd0);
    check("midrst_busy", dut.busy_q, 32'd0);
    check("midrst_if_ready", 32'(if_ready_o), 32'd1);
    check("midrst_rs2_addr", 32'(rs2_addr_o), 32'd0);
    tick();
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Instruction decode stage of the E10 RV32I pipeline, between fetch and execute. It holds one fetched instruction and drives the regfile read addresses from it. It stalls on register hazards using a 32-entry busy scoreboard, and registers the decoded operands and immediates toward execute over a valid/ready handshake. The regfile read ports are combinational: data returns in the same cycle as the address.

## Interface
- No parameters. XLEN is fixed at 32; compressed instructions are not supported.
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- if_valid_i / if_ready_o  in/out  1  fetch handshake
- if_instr_i, if_pc_i  in  32  fetched instruction and its PC
- rs1_addr_o, rs2_addr_o  out  5  regfile read addresses
- rs1_data_i, rs2_data_i  in  32  regfile read data, same cycle as the address
- wb_valid_i  in  1  writeback commits this cycle
- wb_rd_i  in  5  writeback destination register
- wb_data_i  in  32  writeback data; used only under the bypass macro
- flush_i  in  1  kill the held instruction and the output instruction
- ex_valid_o / ex_ready_i  out/in  1  execute handshake
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  32  decoded fields
- ex_rd_o  out  5  destination register; 0 when there is no write
- ex_opcode_o  out  7  opcode
- ex_funct3_o  out  3  funct3 field
- ex_funct7b5_o  out  1  instruction bit 30
- ex_illegal_o  out  1  unsupported encoding

## Operation
- **Hold register D.** It captures if_instr_i and if_pc_i when if_valid_i && if_ready_o, and sets d_v.
- **Ready and advance.** if_ready_o = !d_v || adv. adv = d_v && !hz && (!ex_valid_o || ex_ready_i) && !flush_i.
- **Register usage by opcode:**
  - LUI, AUIPC, JAL: rd only.
  - JALR, LOAD, OP-IMM: rs1 and rd.
  - BRANCH, STORE: rs1 and rs2.
  - OP: rs1, rs2 and rd.
  - MISC-MEM, SYSTEM: no registers.
  - Any other opcode, or instr[1:0] != 2'b11: illegal. No registers are used; the instruction passes with ex_illegal_o=1.
- **Immediates.** I, S, B, U and J formats, sign-extended per RV32I. The value is 0 for R-type and illegal encodings.
- **Read addresses.** rs1_addr_o = instr[19:15] and rs2_addr_o = instr[24:20] from D, whether or not the operands are used.
- **Operand data.** Register x0 reads as 0 regardless of rs*_data_i.
- **Hazard hz.** Asserted when a used rs1 or rs2 (≠0) is busy, or a written rd (≠0) is busy (WAW).
- **Scoreboard busy[31:1]:**
  - On adv with a written rd≠0: set busy[rd].
  - On wb_valid_i: clear busy[wb_rd_i].
  - Same index set and cleared in the same cycle: set wins.
  - busy[0] is constant 0.
- **Flush (flush_i):**
  - d_v and ex_valid_o clear at the next edge; no busy bit is set that cycle.
  - If ex_valid_o and ex_rd_o≠0, busy[ex_rd_o] is cleared.
  - All other busy bits are untouched.
- **Output register.** It loads on adv, drops ex_valid_o on ex_ready_i && !adv, and holds while ex_valid_o && !ex_ready_i.

## Timing
- Reset values:
  - d_v=0, busy=0.
  - All ex_* outputs = 0 and ex_valid_o=0.
  - rs*_addr_o=0.
  - if_ready_o=1.
- Accept at edge N makes D valid at edge N. With no hazard, ex_valid_o is high from edge N+1, for a minimum latency of 1 stage register past D.
- Throughput is 1 instruction per cycle with no hazards.
- A hazardous instruction waits in D, and if_ready_o=0.
- Without bypass, a dependency on writeback at edge M is released at edge M, and the instruction advances at edge M+1.
- ex_* outputs stay stable while ex_valid_o && !ex_ready_i.
- Asserting rst_i mid-operation returns every register to its reset value immediately.

## Configuration
- **RV32_WB_BYPASS_EN defined:** when wb_valid_i && wb_rd_i==rs (≠0), that source is treated as not busy and takes wb_data_i instead of rs*_data_i. The instruction advances in the same cycle as the writeback.
- **RV32_WB_BYPASS_EN undefined:** wb_data_i is ignored, and a dependency costs one extra cycle after writeback.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) → 1 cycle after D is valid: ex_valid_o=1, ex_rd_o=1, ex_imm_o=5, ex_rs1_data_o=0, busy[1]=1.
- `add x3,x1,x2` while busy[1]=1 → if_ready_o=0 and no advance. With wb_valid_i, wb_rd_i=1, wb_data_i=7: under bypass it advances that cycle with ex_rs1_data_o=7; without bypass it advances 1 cycle later using rs1_data_i.
- ex_ready_i held 0 for 3 cycles while holding `lui x5,0x12345` → ex_imm_o=0x12345000 stays stable and fetch stalls once D is full.
- Flush with `addi x4,...` in the output register and an instruction in D → both dropped, busy[4]=0, if_ready_o=1.
- 0xFFFFFFFF fetched → ex_illegal_o=1, ex_rd_o=0, no busy bit set.
- `addi x6,...` advances in the same cycle as wb_rd_i=6 → busy[6]=1 (set wins).
